// File: rtl/lsu_pkg.sv
// lsu_pkg: funct3 encodings and FSM state type shared by the load/store unit.
package lsu_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} lsu_state_e;
endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// lsu_mem_ctrl_if: data-memory request/grant/rvalid bus between the LSU and memory.
interface lsu_mem_ctrl_if;
  logic        mem_req;
  logic        mem_gnt;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  modport master(output mem_req, mem_we, mem_be, mem_addr, mem_wdata, input mem_gnt, mem_rvalid, mem_rdata);
  modport slave(input mem_req, mem_we, mem_be, mem_addr, mem_wdata, output mem_gnt, mem_rvalid, mem_rdata);
endinterface

// File: rtl/lsu_align.sv
// lsu_align: byte-lane decode, store replication, access checks and load extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic        illegal,
  output logic        misaligned,
  output logic [31:0] ext
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    illegal    = we ? !(funct3 inside {F3_B, F3_H, F3_W}) : !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    misaligned = (funct3[1:0] == 2'b01 && addr_lo[0]) || (funct3 == F3_W && addr_lo != 2'b00);
    be         = !we ? 4'b1111 :
                 funct3[1:0] == 2'b00 ? 4'b0001 << addr_lo :
                 funct3[1:0] == 2'b01 ? (addr_lo[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdata_rep  = funct3[1:0] == 2'b00 ? {4{wdata[7:0]}} :
                 funct3[1:0] == 2'b01 ? {2{wdata[15:0]}} : wdata;
    b          = rdata[{addr_lo, 3'b000} +: 8];
    h          = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    ext        = funct3 == F3_B  ? {{24{b[7]}}, b} :
                 funct3 == F3_H  ? {{16{h[15]}}, h} :
                 funct3 == F3_BU ? {24'h0, b} :
                 funct3 == F3_HU ? {16'h0, h} : rdata;
  end
endmodule

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: single-outstanding load/store unit bridging the core data port to a variable-latency memory bus.
// Optional REQ/WAIT abort timer enabled by defining LSU_TIMEOUT_EN.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  lsu_mem_ctrl_if.master mem
);
  lsu_state_e  state_q, state_d;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [1:0]  lo_q;
  logic [3:0]  be;
  logic [31:0] wdata_rep, ext;
  logic        illegal, misaligned, bad, acc, go, tmo;
  assign req_ready = state_q == IDLE;
  assign acc       = req_ready && req_valid;
  assign bad       = illegal || misaligned;
  assign go        = acc && !bad;
  // In IDLE the decoder sees the incoming request; afterwards the registered one drives load extension.
  lsu_align u_align (
    .we        (req_ready ? req_we : we_q),
    .funct3    (req_ready ? req_funct3 : f3_q),
    .addr_lo   (req_ready ? req_addr[1:0] : lo_q),
    .wdata     (req_wdata),
    .rdata     (mem.mem_rdata),
    .be        (be),
    .wdata_rep (wdata_rep),
    .illegal   (illegal),
    .misaligned(misaligned),
    .ext       (ext)
  );
`ifdef LSU_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q;
  assign tmo = (state_q == REQ || state_q == WAIT) && cnt_q == CNT_W'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt_q <= '0;
    else cnt_q <= state_d != state_q ? '0 : (state_q == REQ || state_q == WAIT) ? cnt_q + 1'b1 : cnt_q;
`else
  logic [CNT_W-1:0] unused_cfg;
  assign unused_cfg = CNT_W'(TIMEOUT_CYCLES);
  assign tmo = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (acc) state_d = bad ? RESP : REQ;
      REQ:     if (tmo) state_d = RESP; else if (mem.mem_gnt) state_d = we_q ? RESP : WAIT;
      WAIT:    if (tmo || mem.mem_rvalid) state_d = RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q       <= IDLE;
      we_q          <= 1'b0;
      f3_q          <= 3'b000;
      lo_q          <= 2'b00;
      resp_valid    <= 1'b0;
      resp_err      <= 1'b0;
      resp_rdata    <= '0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_be    <= 4'b0000;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
    end else begin
      state_q <= state_d;
      if (go) begin
        we_q          <= req_we;
        f3_q          <= req_funct3;
        lo_q          <= req_addr[1:0];
        mem.mem_be    <= be;
        mem.mem_addr  <= {req_addr[31:2], 2'b00};
        mem.mem_wdata <= wdata_rep;
      end
      mem.mem_req <= state_d == REQ;
      mem.mem_we  <= state_d == REQ && (req_ready ? req_we : we_q);
      resp_valid  <= state_d == RESP;
      resp_err    <= (acc && bad) || tmo;
      resp_rdata  <= (state_q == WAIT && mem.mem_rvalid && !tmo) ? ext : '0;
    end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: scoreboard bench for lsu_mem_ctrl; timeout scenario runs when LSU_TIMEOUT_EN is defined.
module tb_lsu_mem_ctrl;
  logic        clk = 1'b0, reset = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;
  int          cyc = 0, vectors = 0, miscompares = 0;
  typedef struct {logic [31:0] rdata; logic err; int at;} exp_t;
  exp_t sb[$];
  lsu_mem_ctrl_if bus();
  lsu_mem_ctrl #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  // Response monitor: every resp_valid pulse must match the oldest expected entry.
  always @(negedge clk) if (resp_valid) begin
    exp_t e;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $display("FAIL resp_unexpected: resp_valid=1 at cycle %0d, want no response", cyc);
    end else begin
      e = sb.pop_front();
      if (resp_rdata !== e.rdata || resp_err !== e.err || cyc !== e.at || req_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL resp: got rdata=%h err=%b cyc=%0d ready=%b, want rdata=%h err=%b cyc=%0d ready=0",
                 resp_rdata, resp_err, cyc, req_ready, e.rdata, e.err, e.at);
      end
    end
  end
  task automatic drain(input string nm);
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL %s timeout: %0d responses outstanding, want 0", nm, sb.size());
      sb.delete();
    end
  endtask
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr, wd, rd,
                        input int g, r, input logic [3:0] ebe, input logic [31:0] ewd, erd,
                        input logic eerr, input string nm);
    int n;
    @(negedge clk);
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s ready: got %b want 1", nm, req_ready);
    end
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd; n = cyc;
    sb.push_back('{erd, eerr, n + (eerr ? 1 : we ? 2 + g : 2 + g + r)});
    @(negedge clk);
    req_valid = 1'b0; req_wdata = $urandom; req_addr = $urandom;
    if (eerr) begin
      vectors++;
      if (bus.mem_req !== 1'b0) begin
        miscompares++;
        $display("FAIL %s err_no_req: got mem_req=%b want 0", nm, bus.mem_req);
      end
    end else begin
      for (int i = 0; i <= g; i++) begin
        vectors++;
        if ({bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr} !== {1'b1, we, ebe, addr & 32'hFFFF_FFFC} ||
            (we && bus.mem_wdata !== ewd)) begin
          miscompares++;
          $display("FAIL %s bus: got req=%b we=%b be=%b addr=%h wdata=%h, want req=1 we=%b be=%b addr=%h wdata=%h",
                   nm, bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata,
                   we, ebe, addr & 32'hFFFF_FFFC, ewd);
        end
        if (i == g) bus.mem_gnt = 1'b1;
        @(negedge clk);
      end
      bus.mem_gnt = 1'b0;
      if (!we) begin
        vectors++;
        if (bus.mem_req !== 1'b0) begin
          miscompares++;
          $display("FAIL %s wait_req: got mem_req=%b want 0", nm, bus.mem_req);
        end
        repeat (r - 1) @(negedge clk);
        bus.mem_rdata = rd; bus.mem_rvalid = 1'b1;
        @(negedge clk);
        bus.mem_rvalid = 1'b0; bus.mem_rdata = $urandom;
      end
    end
    drain(nm);
  endtask
  task automatic check_idle(input string nm);
    vectors++;
    if ({req_ready, resp_valid, resp_err, resp_rdata, bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata}
        !== {1'b1, 2'b00, 32'h0, 2'b00, 4'h0, 64'h0}) begin
      miscompares++;
      $display("FAIL %s: got ready=%b rv=%b err=%b rdata=%h req=%b we=%b be=%b addr=%h wdata=%h, want ready=1 and all else 0",
               nm, req_ready, resp_valid, resp_err, resp_rdata, bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata);
    end
  endtask
  task automatic test_reset;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_idle("reset_state");
    reset = 1'b1;
  endtask
  task automatic test_stores;
    do_req(1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 0, 0, 0, 4'b1000, 32'hA5A5_A5A5, 0, 0, "sb_lane3");
    do_req(1, 3'b000, 32'h0000_1001, 32'h1234_5677, 0, 1, 0, 4'b0010, 32'h7777_7777, 0, 0, "sb_lane1");
    do_req(1, 3'b001, 32'h0000_4002, 32'h1234_BEEF, 0, 0, 0, 4'b1100, 32'hBEEF_BEEF, 0, 0, "sh_upper");
    do_req(1, 3'b001, 32'h0000_4000, 32'h0000_C0DE, 0, 2, 0, 4'b0011, 32'hC0DE_C0DE, 0, 0, "sh_lower");
    do_req(1, 3'b010, 32'h0000_8004, 32'hDEAD_BEEF, 0, 0, 0, 4'b1111, 32'hDEAD_BEEF, 0, 0, "sw");
  endtask
  task automatic test_loads;
    do_req(0, 3'b000, 32'h0000_2002, 0, 32'h1280_3456, 3, 2, 4'b1111, 0, 32'hFFFF_FF80, 0, "lb_neg");
    do_req(0, 3'b101, 32'h0000_2002, 0, 32'h8001_1234, 0, 1, 4'b1111, 0, 32'h0000_8001, 0, "lhu");
    do_req(0, 3'b001, 32'h0000_3000, 0, 32'h5555_F00F, 1, 1, 4'b1111, 0, 32'hFFFF_F00F, 0, "lh_neg");
    do_req(0, 3'b100, 32'h0000_3003, 0, 32'h9A00_0000, 0, 3, 4'b1111, 0, 32'h0000_009A, 0, "lbu");
    do_req(0, 3'b000, 32'h0000_3001, 0, 32'h0000_7F00, 0, 1, 4'b1111, 0, 32'h0000_007F, 0, "lb_pos");
    do_req(0, 3'b010, 32'h0000_300C, 0, 32'hCAFE_F00D, 2, 2, 4'b1111, 0, 32'hCAFE_F00D, 0, "lw");
  endtask
  task automatic test_errors;
    do_req(0, 3'b010, 32'h0000_0006, 0, 0, 0, 0, 0, 0, 0, 1, "lw_misaligned");
    do_req(0, 3'b011, 32'h0000_0000, 0, 0, 0, 0, 0, 0, 0, 1, "load_f3_011");
    do_req(1, 3'b100, 32'h0000_0000, 0, 0, 0, 0, 0, 0, 0, 1, "store_f3_100");
    do_req(1, 3'b001, 32'h0000_0001, 0, 0, 0, 0, 0, 0, 0, 1, "sh_misaligned");
    do_req(0, 3'b101, 32'h0000_0003, 0, 0, 0, 0, 0, 0, 0, 1, "lhu_misaligned");
    do_req(1, 3'b010, 32'h0000_0002, 0, 0, 0, 0, 0, 0, 0, 1, "sw_misaligned");
  endtask
  task automatic test_back_to_back;
    int n;
    @(negedge clk);
    n = cyc;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_0002;
    sb.push_back('{32'h0, 1'b1, n + 1});
    sb.push_back('{32'h0, 1'b1, n + 3});
    @(negedge clk);
    vectors++;
    if (req_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_resp_ready: got %b want 0", req_ready);
    end
    @(negedge clk);
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_idle_ready: got %b want 1", req_ready);
    end
    @(negedge clk);
    req_valid = 1'b0;
    drain("b2b");
  endtask
  task automatic test_reset_mid;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_0300;
    @(negedge clk);
    req_valid = 1'b0; bus.mem_gnt = 1'b1;
    @(negedge clk);
    bus.mem_gnt = 1'b0;
    reset = 1'b0;
    #1;
    check_idle("async_reset");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    bus.mem_rdata = 32'h1357_9BDF; bus.mem_rvalid = 1'b1;
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("late_rvalid_ignored");
  endtask
`ifdef LSU_TIMEOUT_EN
  task automatic test_timeout;
    int n;
    @(negedge clk);
    n = cyc;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_0040;
    sb.push_back('{32'h0, 1'b1, n + 5});
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (bus.mem_req !== 1'b1) begin
        miscompares++;
        $display("FAIL timeout_req_%0d: got mem_req=%b want 1", i, bus.mem_req);
      end
      @(negedge clk);
    end
    vectors++;
    if (bus.mem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_drop: got mem_req=%b want 0", bus.mem_req);
    end
    drain("timeout");
  endtask
`endif
  initial begin
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    test_reset;
    test_stores;
    test_loads;
    test_errors;
    test_back_to_back;
    test_reset_mid;
`ifdef LSU_TIMEOUT_EN
    test_timeout;
`endif
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1);
  end
endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store unit sitting between the RV32I core's data port and the data-memory side of the memory bus.
- Accepts one core load/store request at a time and generates byte enables and lane-replicated write data.
- Drives a request/grant/rvalid handshake towards memory, then returns sign- or zero-extended load data with a one-cycle response pulse.
- Replaces the core's direct word-only combinational dmem access, so the memory side may have variable latency.

Parameters:
- TIMEOUT_CYCLES, 255: consecutive cycles in REQ/WAIT before abort. Used only with LSU_TIMEOUT_EN.
- CNT_W, 8: width of the timeout counter. Must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock; all state changes on the posedge.
- reset  in  1  asynchronous, active-low reset. The port keeps the codebase name "reset"; 0 = reset asserted.
- req_valid  in  1  core presents a request.
- req_ready  out  1  LSU can accept a request (IDLE only).
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU or SB/SH/SW).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned access, illegal funct3, or timeout. Qualified by resp_valid.
- mem_req  out  1  memory request.
- mem_gnt  in  1  memory accepts the request this cycle.
- mem_we  out  1  write strobe.
- mem_be  out  4  byte enables.
- mem_addr  out  32  word address: {addr[31:2], 2'b00}.
- mem_wdata  out  32  lane-replicated store data.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  32  raw read word.

Behaviour:
- Reset (reset == 0, asynchronous):
  - state = IDLE.
  - resp_valid, resp_err, mem_req, mem_we = 0.
  - resp_rdata, mem_addr, mem_wdata = 0; mem_be = 4'b0000.
  - The timeout counter is cleared.
  - Reset mid-transaction abandons it; a later mem_rvalid is ignored in IDLE.
- States are IDLE, REQ, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - A request is accepted when req_valid is high; it is registered (we, funct3, addr, wdata).
  - Illegal funct3 or misaligned access: go to RESP with err = 1. No memory request is issued.
  - Legal access: go to REQ.
- REQ:
  - mem_req = 1, and mem_we/mem_be/mem_addr/mem_wdata are held stable until mem_gnt.
  - On mem_gnt, a store goes to RESP and a load goes to WAIT.
  - mem_rvalid is ignored in REQ; memory must not return data in the grant cycle.
- WAIT:
  - mem_req = 0.
  - On mem_rvalid, the extended data is registered and the state goes to RESP.
- RESP:
  - resp_valid = 1 for exactly one cycle, then the state returns to IDLE.
  - req_ready = 0 during RESP, so back-to-back accepts are spaced at least one IDLE cycle apart.
- Latency, with the accept at cycle N:
  - Store with immediate grant: resp_valid at N+2.
  - Load with grant at N+1 and rvalid at N+2: resp_valid at N+3.
  - Error: resp_valid at N+1.
- Legal funct3 values:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - All others are illegal.
- Misaligned access: H with addr[0] = 1, or W with addr[1:0] != 0.
- Store lanes:
  - SB: be = 1 << addr[1:0]; wdata = {4{wdata[7:0]}}.
  - SH: be = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{wdata[15:0]}}.
  - SW: be = 4'b1111.
- Loads:
  - mem_be = 4'b1111.
  - The byte or halfword is selected by addr[1:0], then sign-extended (LB/LH) or zero-extended (LBU/LHU).
- Outputs from REQ/WAIT/RESP are registered; req_ready is decoded from the state.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- When defined:
  - The counter increments each cycle in REQ or WAIT and clears on every state change.
  - When it reaches TIMEOUT_CYCLES, mem_req drops, the state goes to RESP with err = 1 and rdata = 0, and any late mem_rvalid is ignored.
- When undefined: no counter exists, and REQ/WAIT wait indefinitely.

Decomposition:
- Shared package lsu_pkg holds:
  - funct3 encoding constants for loads and stores.
  - The typedef enum logic [1:0] lsu_state_e {IDLE, REQ, WAIT, RESP}.
- One sub-module, lsu_align, is purely combinational. It takes funct3 and addr[1:0] and produces:
  - be, replicated wdata, the illegal/misaligned flags, and the load-extension result.

Test Plan:
- SB, addr = 0x0000_1003, wdata = 0x0000_00A5, grant immediate -> mem_be = 4'b1000, mem_wdata = 0xA5A5_A5A5, mem_addr = 0x0000_1000, resp_valid at N+2, err = 0.
- LB, addr = 0x0000_2002, mem_rdata = 0x1280_3456, grant delayed 3 cycles, rvalid 2 cycles after grant -> resp_rdata = 0xFFFF_FF80, single-cycle resp_valid.
- LHU, addr = 0x0000_2002, mem_rdata = 0x8001_1234 -> resp_rdata = 0x0000_8001.
- LW, addr = 0x0000_0006 -> resp_valid at N+1 with err = 1, mem_req never asserted. funct3 = 011 load behaves the same.
- Reset asserted in WAIT, then mem_rvalid pulses after release -> LSU stays IDLE, no resp_valid, all outputs at reset values.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES = 4, mem_gnt held 0 -> mem_req drops after 4 cycles, resp_err = 1, resp_rdata = 0.
